// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared state encoding and sizing helper for the MAC stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_stream_datapath.sv
// ============================================================================
// Module      : mac_stream_datapath
// Description : Operand/product pipeline, saturating accumulator and term counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_stream_datapath #(
    parameter int DATA_W  = 4,
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic              i_xfer,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_last,
    output logic              o_stage1_valid,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_overflow
);
    import mac_pkg::*;

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 2;
    localparam int EXT_W  = SUM_W - PROD_W;
    localparam int CNT_W  = clog2(N_TERMS + 1);

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [ACC_W-1:0] c_SMAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_SMIN     = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] c_UMAX     = {ACC_W{1'b1}};

    logic              r_mode;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_v1;
    logic [PROD_W-1:0] r_prod;
    logic              r_v2;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_prod_ext;
    logic [SUM_W-1:0]  w_acc_ext;
    logic [SUM_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_clamp;

    // Extending both operands to the product width lets one unsigned
    // multiplier serve both modes: the low PROD_W bits are exact either way.
    assign w_a_ext = r_mode ? {{DATA_W{r_a[DATA_W-1]}}, r_a} : {{DATA_W{1'b0}}, r_a};
    assign w_b_ext = r_mode ? {{DATA_W{r_b[DATA_W-1]}}, r_b} : {{DATA_W{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_prod_ext = r_mode ? {{EXT_W{r_prod[PROD_W-1]}}, r_prod}
                               : {{EXT_W{1'b0}}, r_prod};
    assign w_acc_ext  = r_mode ? {{2{r_acc[ACC_W-1]}}, r_acc} : {2'b00, r_acc};
    assign w_sum      = w_acc_ext + w_prod_ext;

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        w_clamp    = 1'b0;
        if (r_mode) begin
            // In range only when the three top bits agree.
            if ((w_sum[SUM_W-1:ACC_W-1] != 3'b000) &&
                (w_sum[SUM_W-1:ACC_W-1] != 3'b111)) begin
                w_clamp    = 1'b1;
                w_acc_next = w_sum[SUM_W-1] ? c_SMIN : c_SMAX;
            end
        end else if (w_sum[SUM_W-1:ACC_W] != 2'b00) begin
            w_clamp    = 1'b1;
            w_acc_next = c_UMAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_v1   <= 1'b0;
            r_prod <= '0;
            r_v2   <= 1'b0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_mode <= i_mode;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_v1 <= i_xfer;
            r_v2 <= r_v1;
            if (i_xfer) begin
                r_a   <= i_a;
                r_b   <= i_b;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_v1) begin
                r_prod <= w_prod;
            end
            if (r_v2) begin
                r_acc <= w_acc_next;
                if (w_clamp) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign o_last         = i_xfer && (r_cnt == c_LAST_CNT);
    assign o_stage1_valid = r_v1;
    assign o_acc          = r_acc;
    assign o_overflow     = r_ovf;

endmodule

`default_nettype wire

// File: rtl/mac_stream.sv
// ============================================================================
// Module      : mac_stream
// Description : Pipelined multiply-accumulate engine: control FSM and handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_stream #(
    parameter int DATA_W  = 4,
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              signed_mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out,
    output logic              done,
    output logic              busy,
    output logic              overflow
);
    import mac_pkg::*;

    mac_state_t       r_state;
    mac_state_t       w_next_state;
    logic [ACC_W-1:0] r_out;

    logic             w_start;
    logic             w_xfer;
    logic             w_last;
    logic             w_stage1_valid;
    logic [ACC_W-1:0] w_acc;

    assign w_start = (r_state == ST_IDLE) && go;
    assign w_xfer  = (r_state == ST_LOAD) && in_valid;

    mac_stream_datapath #(
        .DATA_W  (DATA_W),
        .N_TERMS (N_TERMS),
        .ACC_W   (ACC_W)
    ) u_datapath (
        .clk            (clk),
        .rst            (rst),
        .i_start        (w_start),
        .i_mode         (signed_mode),
        .i_xfer         (w_xfer),
        .i_a            (A),
        .i_b            (B),
        .o_last         (w_last),
        .o_stage1_valid (w_stage1_valid),
        .o_acc          (w_acc),
        .o_overflow     (overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (go)     w_next_state = ST_LOAD;
            ST_LOAD:  if (w_last) w_next_state = ST_DRAIN;
            // Once stage 1 is empty, the product stage retires into the
            // accumulator on this same edge, so the pipe is empty in DONE.
            ST_DRAIN: if (!w_stage1_valid) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // The accumulator clears on go, so the result is captured separately
    // to keep `out` stable until the next operation finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (r_state == ST_DONE) begin
            r_out <= w_acc;
        end
    end

    assign in_ready = (r_state == ST_LOAD);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign out      = (r_state == ST_DONE) ? w_acc : r_out;

endmodule

`default_nettype wire
